// File: rtl/sensor_sr_receiver.sv
// Chip-side emulation of the speckle sensor's column/row shift registers, row reset and
// pixel write key, with a small pixel array and registered row readback.
module sensor_sr_receiver #(
    parameter int NB_COL  = 8,
    parameter int NB_ROW  = 8,
    parameter int NB_ADDR = 3,
    parameter int NB_CNT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clk_col,
    input  logic               i_data_col,
    input  logic               i_clk_row,
    input  logic               i_data_row,
    input  logic               i_write_key,
    input  logic               i_rst_row,
    input  logic [NB_ADDR-1:0] i_rd_row,
    output logic [NB_COL-1:0]  o_col_sr,
    output logic [NB_ROW-1:0]  o_row_sr,
    output logic [7:0]         o_col_cnt,
    output logic [NB_CNT-1:0]  o_key_cnt,
    output logic               o_key_done,
    output logic               o_col_ovf,
    output logic [NB_COL-1:0]  o_rd_data
);

    logic               clk_col_prev_q, clk_row_prev_q, key_prev_q, rst_row_prev_q;
    logic               rise_col, rise_row, rise_key, rise_rst;
    logic [NB_COL-1:0]  col_sr_q, col_sr_d;
    logic [NB_ROW-1:0]  row_sr_q, row_sr_d;
    logic [7:0]         col_cnt_q, col_cnt_d;
    logic               col_ovf_q, col_ovf_d;
    logic [NB_CNT-1:0]  key_cnt_q, key_cnt_d;
    logic               key_done_q;
    logic [NB_COL-1:0]  rd_data_q, rd_data_d;
    logic [NB_COL-1:0]  pix_q [NB_ROW];

    // History resets to 1 so a line already high at reset release is not an edge.
    assign rise_col = i_clk_col   & ~clk_col_prev_q;
    assign rise_row = i_clk_row   & ~clk_row_prev_q;
    assign rise_key = i_write_key & ~key_prev_q;
    assign rise_rst = i_rst_row   & ~rst_row_prev_q;

    always_comb begin
        col_sr_d  = col_sr_q;
        col_cnt_d = col_cnt_q;
        col_ovf_d = col_ovf_q;
        row_sr_d  = row_sr_q;
        key_cnt_d = key_cnt_q;

        if (rise_col) begin
            col_sr_d = {col_sr_q[NB_COL-2:0], i_data_col};
        end

        // A key coincident with a column edge starts a new frame holding that one bit.
        if (rise_key) begin
            col_cnt_d = rise_col ? 8'd1 : 8'd0;
            key_cnt_d = key_cnt_q + NB_CNT'(1);
        end else if (rise_col) begin
            if (col_cnt_q >= 8'(NB_COL)) begin
                col_ovf_d = 1'b1;
            end
            if (col_cnt_q != 8'hFF) begin
                col_cnt_d = col_cnt_q + 8'd1;
            end
        end

        if (rise_rst) begin
            row_sr_d = '0;
        end else if (rise_row) begin
            row_sr_d = {row_sr_q[NB_ROW-2:0], i_data_row};
        end
    end

    // Out-of-range addresses fall through to zero.
    always_comb begin
        rd_data_d = '0;
        for (int r = 0; r < NB_ROW; r++) begin
            if (i_rd_row == NB_ADDR'(r)) begin
                rd_data_d = pix_q[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_col_prev_q <= 1'b1;
            clk_row_prev_q <= 1'b1;
            key_prev_q     <= 1'b1;
            rst_row_prev_q <= 1'b1;
            col_sr_q       <= '0;
            row_sr_q       <= '0;
            col_cnt_q      <= '0;
            col_ovf_q      <= 1'b0;
            key_cnt_q      <= '0;
            key_done_q     <= 1'b0;
            rd_data_q      <= '0;
            for (int r = 0; r < NB_ROW; r++) begin
                pix_q[r] <= '0;
            end
        end else begin
            clk_col_prev_q <= i_clk_col;
            clk_row_prev_q <= i_clk_row;
            key_prev_q     <= i_write_key;
            rst_row_prev_q <= i_rst_row;
            col_sr_q       <= col_sr_d;
            row_sr_q       <= row_sr_d;
            col_cnt_q      <= col_cnt_d;
            col_ovf_q      <= col_ovf_d;
            key_cnt_q      <= key_cnt_d;
            key_done_q     <= rise_key;
            rd_data_q      <= rd_data_d;
            // Key writes use the pre-shift registers of this same cycle.
            for (int r = 0; r < NB_ROW; r++) begin
                if (rise_key && row_sr_q[r]) begin
                    pix_q[r] <= col_sr_q;
                end
            end
        end
    end

    assign o_col_sr   = col_sr_q;
    assign o_row_sr   = row_sr_q;
    assign o_col_cnt  = col_cnt_q;
    assign o_key_cnt  = key_cnt_q;
    assign o_key_done = key_done_q;
    assign o_col_ovf  = col_ovf_q;
    assign o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_sensor_sr_receiver.sv
// Self-checking bench for sensor_sr_receiver: a default 8x8 instance plus a 6-row instance
// sharing the same stimulus to exercise out-of-range readback.
module tb_sensor_sr_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_clk_col = 1'b0, i_data_col = 1'b0;
    logic        i_clk_row = 1'b0, i_data_row = 1'b0;
    logic        i_write_key = 1'b0, i_rst_row = 1'b0;
    logic [2:0]  i_rd_row = 3'd0;

    logic [7:0]  o_col_sr, o_row_sr, o_col_cnt, o_rd_data;
    logic [15:0] o_key_cnt;
    logic        o_key_done, o_col_ovf;

    logic [7:0]  s_col_sr, s_col_cnt, s_rd_data;
    logic [5:0]  s_row_sr;
    logic [15:0] s_key_cnt;
    logic        s_key_done, s_col_ovf;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp6_q[$];

    always #5 clk = ~clk;

    sensor_sr_receiver dut (
        .clk(clk), .rst(rst),
        .i_clk_col(i_clk_col), .i_data_col(i_data_col),
        .i_clk_row(i_clk_row), .i_data_row(i_data_row),
        .i_write_key(i_write_key), .i_rst_row(i_rst_row), .i_rd_row(i_rd_row),
        .o_col_sr(o_col_sr), .o_row_sr(o_row_sr), .o_col_cnt(o_col_cnt),
        .o_key_cnt(o_key_cnt), .o_key_done(o_key_done), .o_col_ovf(o_col_ovf),
        .o_rd_data(o_rd_data)
    );

    sensor_sr_receiver #(.NB_ROW(6)) dut6 (
        .clk(clk), .rst(rst),
        .i_clk_col(i_clk_col), .i_data_col(i_data_col),
        .i_clk_row(i_clk_row), .i_data_row(i_data_row),
        .i_write_key(i_write_key), .i_rst_row(i_rst_row), .i_rd_row(i_rd_row),
        .o_col_sr(s_col_sr), .o_row_sr(s_row_sr), .o_col_cnt(s_col_cnt),
        .o_key_cnt(s_key_cnt), .o_key_done(s_key_done), .o_col_ovf(s_col_ovf),
        .o_rd_data(s_rd_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic col_bit(input logic b);
        i_data_col = b; i_clk_col = 1'b1; step();
        i_clk_col = 1'b0; step();
    endtask

    task automatic row_bit(input logic b);
        i_data_row = b; i_clk_row = 1'b1; step();
        i_clk_row = 1'b0; step();
    endtask

    task automatic col_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) col_bit(v[i]);
    endtask

    task automatic row_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) row_bit(v[i]);
    endtask

    // Push the expected row for both instances, then pop and compare once registered.
    task automatic read_row(input logic [2:0] a, input logic [7:0] e);
        logic [7:0] x, x6;
        i_rd_row = a;
        exp_q.push_back(e);
        exp6_q.push_back((a >= 3'd6) ? 8'h00 : e);
        step();
        x = exp_q.pop_front();
        x6 = exp6_q.pop_front();
        checks++;
        if (o_rd_data !== x) begin
            failures++; $display("FAIL rd_row%0d got=%h exp=%h", a, o_rd_data, x);
        end
        checks++;
        if (s_rd_data !== x6) begin
            failures++; $display("FAIL rd6_row%0d got=%h exp=%h", a, s_rd_data, x6);
        end
    endtask

    task automatic key_pulse(input logic [15:0] exp_cnt);
        i_write_key = 1'b1; step();
        checks++;
        if (o_key_done !== 1'b1) begin
            failures++; $display("FAIL key_done_pulse got=%b exp=1", o_key_done);
        end
        checks++;
        if (o_key_cnt !== exp_cnt) begin
            failures++; $display("FAIL key_cnt got=%0d exp=%0d", o_key_cnt, exp_cnt);
        end
        i_write_key = 1'b0; step();
        checks++;
        if (o_key_done !== 1'b0) begin
            failures++; $display("FAIL key_done_drop got=%b exp=0", o_key_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_clk_col = 1'b1;
        step(); step();
        rst = 1'b0;
        step(); step(); step();
        checks++;
        if (o_col_cnt !== 8'd0) begin
            failures++; $display("FAIL reset_col_cnt got=%0d exp=0", o_col_cnt);
        end
        checks++;
        if (o_col_sr !== 8'h00 || o_row_sr !== 8'h00) begin
            failures++; $display("FAIL reset_srs got=%h/%h exp=00/00", o_col_sr, o_row_sr);
        end
        checks++;
        if (o_key_cnt !== 16'd0 || o_key_done !== 1'b0 || o_col_ovf !== 1'b0 || o_rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_misc got=%0d/%b/%b/%h exp=0/0/0/00", o_key_cnt, o_key_done, o_col_ovf, o_rd_data);
        end
        i_clk_col = 1'b0; step();
    endtask

    task automatic test_col_shift();
        col_byte(8'hB2);
        checks++;
        if (o_col_sr !== 8'hB2) begin
            failures++; $display("FAIL col_sr_b2 got=%h exp=b2", o_col_sr);
        end
        checks++;
        if (o_col_cnt !== 8'd8 || o_col_ovf !== 1'b0) begin
            failures++; $display("FAIL col_cnt8 got=%0d/%b exp=8/0", o_col_cnt, o_col_ovf);
        end
        col_bit(1'b1);
        checks++;
        if (o_col_ovf !== 1'b1 || o_col_cnt !== 8'd9 || o_col_sr !== 8'h65) begin
            failures++; $display("FAIL col_ovf got=%b/%0d/%h exp=1/9/65", o_col_ovf, o_col_cnt, o_col_sr);
        end
    endtask

    task automatic test_key();
        col_byte(8'h3C);
        row_byte(8'h05);
        checks++;
        if (o_row_sr !== 8'h05) begin
            failures++; $display("FAIL row_sr_05 got=%h exp=05", o_row_sr);
        end
        key_pulse(16'd1);
        checks++;
        if (o_col_cnt !== 8'd0) begin
            failures++; $display("FAIL key_clears_cnt got=%0d exp=0", o_col_cnt);
        end
        read_row(3'd0, 8'h3C);
        read_row(3'd1, 8'h00);
        read_row(3'd2, 8'h3C);
        read_row(3'd3, 8'h00);
        read_row(3'd7, 8'h00);
    endtask

    task automatic test_row_reset();
        i_rst_row = 1'b1; i_clk_row = 1'b1; i_data_row = 1'b1; step();
        i_rst_row = 1'b0; i_clk_row = 1'b0; step();
        checks++;
        if (o_row_sr !== 8'h00) begin
            failures++; $display("FAIL row_rst_wins got=%h exp=00", o_row_sr);
        end
    endtask

    task automatic test_simultaneous();
        row_bit(1'b1);
        row_bit(1'b0);
        i_write_key = 1'b1; i_clk_col = 1'b1; i_data_col = 1'b1; step();
        i_write_key = 1'b0; i_clk_col = 1'b0; step();
        checks++;
        if (o_col_cnt !== 8'd1 || o_col_sr !== 8'h79 || o_key_cnt !== 16'd2) begin
            failures++;
            $display("FAIL simul_key_col got=%0d/%h/%0d exp=1/79/2", o_col_cnt, o_col_sr, o_key_cnt);
        end
        read_row(3'd1, 8'h3C);
        read_row(3'd3, 8'h00);
    endtask

    task automatic test_rd_oob();
        col_byte(8'hA5);
        row_byte(8'hFF);
        key_pulse(16'd3);
        read_row(3'd7, 8'hA5);
        read_row(3'd6, 8'hA5);
        read_row(3'd5, 8'hA5);
        read_row(3'd0, 8'hA5);
    endtask

    task automatic test_held_line();
        i_data_col = 1'b0; i_clk_col = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (o_col_cnt !== 8'd1) begin
            failures++; $display("FAIL held_line got=%0d exp=1", o_col_cnt);
        end
        i_clk_col = 1'b0; step();
    endtask

    task automatic test_mid_reset();
        col_bit(1'b1); col_bit(1'b1); col_bit(1'b0);
        row_bit(1'b1);
        i_rd_row = 3'd2;
        rst = 1'b1; step();
        checks++;
        if (o_col_sr !== 8'h00 || o_row_sr !== 8'h00 || o_col_cnt !== 8'd0 || o_key_cnt !== 16'd0
            || o_col_ovf !== 1'b0 || o_key_done !== 1'b0 || o_rd_data !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset got=%h/%h/%0d/%0d/%b/%b/%h exp=all zero", o_col_sr, o_row_sr,
                     o_col_cnt, o_key_cnt, o_col_ovf, o_key_done, o_rd_data);
        end
        rst = 1'b0; step();
        read_row(3'd2, 8'h00);
        read_row(3'd0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_col_shift();
        test_key();
        test_row_reset();
        test_simultaneous();
        test_rd_oob();
        test_held_line();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
